jtag_dbg_dr_bridge: RTL
=======================

# jtag_dbg_dr_bridge

Parametrised JTAG debug data-register bridge between the virtual-JTAG hub signals and the Nios II on-chip debug logic. Supports N_CH selectable data registers of individually configured lengths. Oversamples the raw TCK in the system clock domain, so all state lives on `clk`. Completed DR updates are delivered to the CPU side through a valid/ready handshake with overrun detection, replacing the fixed 4-IR, fixed-length, pulse-only scheme of the previous generation.

## Interface
Parameters:
- N_CH, 4: number of data-register channels; legal 2..16.
- IR_W, 4: instruction register width; must satisfy 2^IR_W ≥ N_CH and IR_W ≥ 2.
- DR_W, 38: maximum DR length in bits.
- CH_LEN, {4{8'd38}}: packed per-channel DR length, 8 bits per channel, channel 0 in LSBs; each entry 1..DR_W.

Ports:
- clk  in  1  system clock; TCK must be high and low for ≥3 clk periods each.
- jrst_n  in  1  asynchronous, active-low reset.
- tck  in  1  raw JTAG TCK, sampled as data.
- tdi  in  1  test data in.
- ena  in  1  node selected by hub.
- usr1  in  1  1 = IR scan, 0 = DR scan.
- vj_cdr, vj_sdr, vj_udr, vj_uir  in  1 each  capture-DR, shift-DR, update-DR, update-IR state levels.
- ir_in  in  IR_W  new instruction from hub.
- cap_data  in  N_CH*DR_W  per-channel capture values.
- upd_ready  in  1  CPU side accepts update.
- tdo  out  1  test data out.
- ir_out  out  IR_W  status returned on IR capture.
- upd_valid  out  1  update pending.
- upd_ch  out  IR_W  channel of pending update.
- upd_data  out  DR_W  DR contents of pending update.
- overrun  out  1  sticky: an update was dropped.

## Operation
- tck passes through a 2-flop synchroniser plus one history flop. tck_rise = sync & ~hist. All JTAG-side actions occur only on the clk cycle where tck_rise=1. Inputs other than tck are sampled on that cycle.
- ir: reset 0. On tck_rise & ena & vj_uir: ir <= ir_in.
- bypass = (ir ≥ N_CH). In bypass, the DR is 1 bit, captures 0, and updates are discarded with no handshake and no overrun.
- len = CH_LEN[ir]. Capture (tck_rise & ena & ~usr1 & vj_cdr): sr <= cap_data slice ir, with bits ≥ len forced to 0.
- Shift (tck_rise & ena & ~usr1 & vj_sdr): sr[len-1] <= tdi, sr[len-2:0] <= sr[len-1:1], bits ≥ len held at 0. tdo = sr[0], combinational from the register.
- Update (tck_rise & ena & ~usr1 & vj_udr), non-bypass:
  - If ~upd_valid or (upd_valid & upd_ready) in the same cycle: upd_data <= sr, upd_ch <= ir, upd_valid <= 1.
  - Otherwise the update is dropped and overrun <= 1.
- Handshake: upd_valid & upd_ready clears upd_valid next cycle unless a new update loads in the same cycle, in which case valid stays 1 with the new data. upd_data and upd_ch are stable while valid.
- ir_out: registered on every tck_rise as {zeros, overrun, upd_valid}.
- overrun clears only on reset or an IR update writing ir_in = all ones.
- usr1 or ~ena suppresses capture, shift and update. IR update (vj_uir) still requires ena.
- Simultaneous state levels (hub fault): priority uir > udr > cdr > sdr.

## Timing
- Reset values: sr, ir, ir_out, upd_data, upd_ch = 0; upd_valid, overrun = 0. tdo = 0.
- tck rising edge to tck_rise pulse: 2–3 clk cycles. tck_rise to tdo change: 1 clk.
- Update at tck_rise cycle N: upd_valid = 1 at N+1.
- Reset mid-shift discards sr immediately. A pending update is lost with no overrun.

## Configuration
- JTAG_DBG_OVERRUN_EN defined: overrun detection as described above.
- Not defined: overrun is tied to 0, ir_out bit 1 reads 0, and a blocked update overwrites upd_data and upd_ch in place (latest wins, upd_valid stays 1).

## Structure
- Package jtag_dbg_pkg holds:
  - the CH_LEN field width constant (8);
  - the ir_out status bit indices;
  - a len_of(ch) function for the CH_LEN slice.
- One sub-module, jtag_dbg_tck_sync: tck synchroniser and rise detector.

## Test plan
- Reset, then IR=1, capture with cap_data ch1 = 38'h2A_DEAD_BEEF, shift 38 bits of tdi=0 -> tdo stream LSB-first equals 0x2A_DEADBEEF.
- CH_LEN ch3 = 16, shift 16'hA5C3 in, update -> upd_valid=1 one clk later, upd_ch=3, upd_data=0x0000A5C3.
- upd_ready=0, two updates back-to-back -> first data retained, overrun=1, next IR capture returns ir_out=2'b11.
- IR = 4'hE with N_CH=4 (bypass) -> shift tdi=1 produces tdo=1 after 1 bit, update produces no upd_valid.
- upd_ready=1 asserted in the same cycle a new update loads -> upd_valid stays 1 and shows the new data.
- jrst_n asserted mid-shift with upd_valid=1 -> all outputs 0 on the next clk; a subsequent scan works normally.

Source files
------------

// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg: shared constants and helpers for the JTAG debug DR bridge.
//   CH_LEN_W          width of one per-channel DR length field
//   MAX_CH            largest supported channel count
//   IROUT_*_BIT       bit positions of the status returned on IR capture
//   len_of()          extracts one channel's DR length from the packed table
package jtag_dbg_pkg;

  localparam int CH_LEN_W          = 8;
  localparam int MAX_CH            = 16;
  localparam int IROUT_VALID_BIT   = 0;
  localparam int IROUT_OVERRUN_BIT = 1;

  // The length table is passed zero-extended to MAX_CH entries so one
  // function serves every N_CH.
  function automatic logic [CH_LEN_W-1:0] len_of(
    input logic [MAX_CH*CH_LEN_W-1:0] ch_len,
    input int unsigned                ch
  );
    return ch_len[ch*CH_LEN_W +: CH_LEN_W];
  endfunction

endpackage

// File: rtl/jtag_dbg_tck_sync.sv
// jtag_dbg_tck_sync: brings raw TCK into the clk domain and flags its rising
// edge for exactly one clk cycle.
//   clk         system clock
//   jrst_n      asynchronous active-low reset
//   i_tck       raw TCK, treated as data
//   o_tck_rise  one-cycle pulse, 2..3 clk after a TCK rising edge
module jtag_dbg_tck_sync (
  input  logic clk,
  input  logic jrst_n,
  input  logic i_tck,
  output logic o_tck_rise
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_tck;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_tck_rise = r_sync & ~r_hist;

endmodule

// File: rtl/jtag_dbg_dr_bridge.sv
// jtag_dbg_dr_bridge: virtual-JTAG DR bridge to the on-chip debug logic.
// N_CH data registers of individual length (CH_LEN); IR values >= N_CH select
// a 1-bit bypass register. Completed DR updates go out over valid/ready.
// All state is on clk; TCK is oversampled.
//
// Optional feature macro: JTAG_DBG_OVERRUN_EN
//   defined   - an update arriving while the previous one is still pending is
//               dropped and the sticky overrun flag is set
//   undefined - the pending update is overwritten in place, overrun reads 0
//
// Ports:
//   clk, jrst_n           system clock, async active-low reset
//   i_tck, i_tdi          raw TCK and TDI from the hub
//   i_ena, i_usr1         node select, 1 = IR scan
//   i_vj_cdr/sdr/udr/uir  hub capture/shift/update-DR and update-IR levels
//   i_ir_in               new instruction
//   i_cap_data            per-channel capture values, channel 0 in LSBs
//   i_upd_ready           CPU side accepts the pending update
//   o_tdo                 test data out
//   o_ir_out              status on IR capture {0.., overrun, upd_valid}
//   o_upd_valid/ch/data   pending update
//   o_overrun             sticky dropped-update flag
module jtag_dbg_dr_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int                         N_CH   = 4,
  parameter int                         IR_W   = 4,
  parameter int                         DR_W   = 38,
  parameter logic [N_CH*CH_LEN_W-1:0]   CH_LEN = {4{8'd38}}
) (
  input  logic                 clk,
  input  logic                 jrst_n,
  input  logic                 i_tck,
  input  logic                 i_tdi,
  input  logic                 i_ena,
  input  logic                 i_usr1,
  input  logic                 i_vj_cdr,
  input  logic                 i_vj_sdr,
  input  logic                 i_vj_udr,
  input  logic                 i_vj_uir,
  input  logic [IR_W-1:0]      i_ir_in,
  input  logic [N_CH*DR_W-1:0] i_cap_data,
  input  logic                 i_upd_ready,
  output logic                 o_tdo,
  output logic [IR_W-1:0]      o_ir_out,
  output logic                 o_upd_valid,
  output logic [IR_W-1:0]      o_upd_ch,
  output logic [DR_W-1:0]      o_upd_data,
  output logic                 o_overrun
);

  localparam int                   LEN_VEC_W = MAX_CH * CH_LEN_W;
  localparam logic [LEN_VEC_W-1:0] CH_LEN_X  = LEN_VEC_W'(CH_LEN);
  localparam logic [IR_W:0]        N_CH_V    = (IR_W + 1)'(N_CH);

  logic [IR_W-1:0]     r_ir;
  logic [IR_W-1:0]     r_ir_out;
  logic [DR_W-1:0]     r_sr;
  logic                r_upd_valid;
  logic [IR_W-1:0]     r_upd_ch;
  logic [DR_W-1:0]     r_upd_data;

  logic                w_tck_rise;
  logic                w_act;
  logic                w_do_uir;
  logic                w_dr_en;
  logic                w_do_udr;
  logic                w_do_cdr;
  logic                w_do_sdr;
  logic                w_bypass;
  logic [IR_W-1:0]     w_ch_idx;
  logic [CH_LEN_W-1:0] w_len;
  logic [DR_W-1:0]     w_mask;
  logic [DR_W-1:0]     w_cap;
  logic [DR_W-1:0]     w_shift;
  logic                w_upd_req;
  logic                w_upd_load;
  logic                w_overrun;
  logic [IR_W-1:0]     w_status;

  jtag_dbg_tck_sync u_tck_sync (
    .clk        (clk),
    .jrst_n     (jrst_n),
    .i_tck      (i_tck),
    .o_tck_rise (w_tck_rise)
  );

  // Hub fault guard: only the highest-priority level acts (uir > udr > cdr > sdr).
  // IR update needs only ena; DR actions are additionally blocked by usr1.
  assign w_act    = w_tck_rise & i_ena;
  assign w_do_uir = w_act & i_vj_uir;
  assign w_dr_en  = w_act & ~i_usr1 & ~i_vj_uir;
  assign w_do_udr = w_dr_en & i_vj_udr;
  assign w_do_cdr = w_dr_en & ~i_vj_udr & i_vj_cdr;
  assign w_do_sdr = w_dr_en & ~i_vj_udr & ~i_vj_cdr & i_vj_sdr;

  // Bypass is a 1-bit register; channel index is forced to 0 there so the
  // table and capture lookups never run out of range.
  assign w_bypass = {1'b0, r_ir} >= N_CH_V;
  assign w_ch_idx = w_bypass ? '0 : r_ir;
  assign w_len    = w_bypass ? CH_LEN_W'(1) : len_of(CH_LEN_X, int'(w_ch_idx));

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DR_W; i++) begin
      w_mask[i] = (i < int'(w_len));
    end
  end

  assign w_cap   = w_bypass ? '0 : (i_cap_data[int'(w_ch_idx)*DR_W +: DR_W] & w_mask);
  // TDI enters at bit len-1; masking also clears stale upper bits left over
  // from a longer channel selected before an IR change without capture.
  assign w_shift = ((r_sr >> 1) | (DR_W'(i_tdi) << (w_len - CH_LEN_W'(1)))) & w_mask;

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_ir <= '0;
    end else if (w_do_uir) begin
      r_ir <= i_ir_in;
    end
  end

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_sr <= '0;
    end else if (w_do_cdr) begin
      r_sr <= w_cap;
    end else if (w_do_sdr) begin
      r_sr <= w_shift;
    end
  end

  assign w_upd_req = w_do_udr & ~w_bypass;

`ifdef JTAG_DBG_OVERRUN_EN
  logic r_overrun;
  logic w_upd_free;
  logic w_upd_drop;

  assign w_upd_free = ~r_upd_valid | i_upd_ready;
  assign w_upd_load = w_upd_req & w_upd_free;
  assign w_upd_drop = w_upd_req & ~w_upd_free;

  // Writing all ones to IR is the only software way to clear the flag.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_overrun <= 1'b0;
    end else if (w_do_uir && (i_ir_in == '1)) begin
      r_overrun <= 1'b0;
    end else if (w_upd_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign w_overrun = r_overrun;
`else
  // Latest update wins: a blocked update replaces the pending one in place.
  assign w_upd_load = w_upd_req;
  assign w_overrun  = 1'b0;
`endif

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_upd_valid <= 1'b0;
      r_upd_ch    <= '0;
      r_upd_data  <= '0;
    end else if (w_upd_load) begin
      r_upd_valid <= 1'b1;
      r_upd_ch    <= r_ir;
      r_upd_data  <= r_sr;
    end else if (r_upd_valid && i_upd_ready) begin
      r_upd_valid <= 1'b0;
    end
  end

  always_comb begin
    w_status                    = '0;
    w_status[IROUT_VALID_BIT]   = r_upd_valid;
    w_status[IROUT_OVERRUN_BIT] = w_overrun;
  end

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      r_ir_out <= '0;
    end else if (w_tck_rise) begin
      r_ir_out <= w_status;
    end
  end

  assign o_tdo       = r_sr[0];
  assign o_ir_out    = r_ir_out;
  assign o_upd_valid = r_upd_valid;
  assign o_upd_ch    = r_upd_ch;
  assign o_upd_data  = r_upd_data;
  assign o_overrun   = w_overrun;

endmodule
